pls_multi_generator: RTL and testbench



---
 rtl/pls_multi_generator.sv | 191 +++++++++++++++++++
 tb/tb_pls_multi_generator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pls_multi_generator.sv
// Multi-group pulse sample generator: streams ramped pulse samples from an external adder.
// Optional macro PLS_TLAST_EN drives m_axis_signal_tlast on the last sample of each period or on the stop sample.
module pls_multi_generator #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_GROUPS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            start,
  input  logic                            stop,
  input  logic [$clog2(NUM_GROUPS)-1:0]   group_select,
  output logic                            busy,
  input  logic [NUM_GROUPS*DATA_SIZE-1:0] cfg_base,
  input  logic [NUM_GROUPS*DATA_SIZE-1:0] cfg_step,
  input  logic [NUM_GROUPS*CNT_W-1:0]     cfg_width,
  input  logic [NUM_GROUPS*CNT_W-1:0]     cfg_period,
  input  logic [NUM_GROUPS*CNT_W-1:0]     cfg_count,
  output logic [DATA_SIZE-1:0]            add_a_tdata,
  output logic [DATA_SIZE-1:0]            add_b_tdata,
  output logic                            add_a_tvalid,
  output logic                            add_b_tvalid,
  input  logic                            add_a_tready,
  input  logic                            add_b_tready,
  input  logic [DATA_SIZE-1:0]            add_result_tdata,
  input  logic                            add_result_tvalid,
  output logic                            add_result_tready,
  output logic [DATA_SIZE-1:0]            m_axis_signal_tdata,
  output logic                            m_axis_signal_tvalid,
  input  logic                            m_axis_signal_tready,
  output logic                            m_axis_signal_tlast
);

  typedef enum logic [2:0] {IDLE, LOAD, OUT, ADD, WAIT} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] acc_q, acc_d;
  logic [DATA_SIZE-1:0] step_q, step_d;
  logic [CNT_W-1:0]     wlim_q, wlim_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     sidx_q, sidx_d;
  logic [CNT_W-1:0]     pidx_q, pidx_d;
  logic                 stop_req_q, stop_req_d;
  logic                 a_pend_q, a_pend_d;
  logic                 b_pend_q, b_pend_d;

  logic [DATA_SIZE-1:0] grp_base   [NUM_GROUPS];
  logic [DATA_SIZE-1:0] grp_step   [NUM_GROUPS];
  logic [CNT_W-1:0]     grp_width  [NUM_GROUPS];
  logic [CNT_W-1:0]     grp_period [NUM_GROUPS];
  logic [CNT_W-1:0]     grp_count  [NUM_GROUPS];

  logic [DATA_SIZE-1:0] sel_base, sel_step;
  logic [CNT_W-1:0]     sel_width, sel_period, sel_count, sel_wlim;
  logic [CNT_W-1:0]     sidx_nxt, pidx_nxt;
  logic                 load_grp;

  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      grp_base[g]   = cfg_base[g*DATA_SIZE +: DATA_SIZE];
      grp_step[g]   = cfg_step[g*DATA_SIZE +: DATA_SIZE];
      grp_width[g]  = cfg_width[g*CNT_W +: CNT_W];
      grp_period[g] = cfg_period[g*CNT_W +: CNT_W];
      grp_count[g]  = cfg_count[g*CNT_W +: CNT_W];
    end
  end

  assign sel_base   = grp_base[group_select];
  assign sel_step   = grp_step[group_select];
  assign sel_width  = grp_width[group_select];
  assign sel_period = grp_period[group_select];
  assign sel_count  = grp_count[group_select];
  // Pulse length clamps to the period so no gap samples remain.
  assign sel_wlim   = (sel_width > sel_period) ? sel_period : sel_width;

  assign sidx_nxt = sidx_q + CNT_W'(1);
  assign pidx_nxt = pidx_q + CNT_W'(1);

  assign busy         = (state_q != IDLE);
  assign add_a_tdata  = acc_q;
  assign add_b_tdata  = step_q;
  assign add_a_tvalid = a_pend_q;
  assign add_b_tvalid = b_pend_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    wlim_d     = wlim_q;
    period_d   = period_q;
    count_d    = count_q;
    sidx_d     = sidx_q;
    pidx_d     = pidx_q;
    a_pend_d   = a_pend_q;
    b_pend_d   = b_pend_q;
    stop_req_d = stop_req_q | stop;
    load_grp   = 1'b0;
    m_axis_signal_tvalid = 1'b0;
    m_axis_signal_tdata  = '0;
    add_result_tready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && sel_period != '0) state_d = LOAD;
      end
      LOAD: begin
        load_grp = 1'b1;
        pidx_d   = '0;
        state_d  = OUT;
      end
      OUT: begin
        m_axis_signal_tvalid = 1'b1;
        m_axis_signal_tdata  = (sidx_q < wlim_q) ? acc_q : '0;
        if (m_axis_signal_tready) begin
          sidx_d = sidx_nxt;
          if (stop_req_q) begin
            state_d = IDLE;
          end else if (sidx_nxt == period_q) begin
            pidx_d = pidx_nxt;
            // A relatched group with zero period could never close a period.
            if ((count_q != '0 && pidx_nxt == count_q) || sel_period == '0) state_d = IDLE;
            else load_grp = 1'b1;
          end else if (sidx_nxt < wlim_q) begin
            a_pend_d = 1'b1;
            b_pend_d = 1'b1;
            state_d  = ADD;
          end
        end
      end
      ADD: begin
        if (add_a_tready) a_pend_d = 1'b0;
        if (add_b_tready) b_pend_d = 1'b0;
        if (!a_pend_d && !b_pend_d) state_d = WAIT;
      end
      WAIT: begin
        add_result_tready = 1'b1;
        if (add_result_tvalid) begin
          acc_d   = add_result_tdata;
          state_d = (stop_req_q || stop) ? IDLE : OUT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_grp) begin
      acc_d    = sel_base;
      step_d   = sel_step;
      wlim_d   = sel_wlim;
      period_d = sel_period;
      count_d  = sel_count;
      sidx_d   = '0;
    end
    if (state_d == IDLE) stop_req_d = 1'b0;
  end

`ifdef PLS_TLAST_EN
  assign m_axis_signal_tlast = (state_q == OUT) && ((sidx_nxt == period_q) || stop_req_q);
`else
  assign m_axis_signal_tlast = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      wlim_q     <= '0;
      period_q   <= '0;
      count_q    <= '0;
      sidx_q     <= '0;
      pidx_q     <= '0;
      stop_req_q <= 1'b0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      wlim_q     <= wlim_d;
      period_q   <= period_d;
      count_q    <= count_d;
      sidx_q     <= sidx_d;
      pidx_q     <= pidx_d;
      stop_req_q <= stop_req_d;
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
    end
  end

endmodule

// File: tb/tb_pls_multi_generator.sv
// Directed bench for pls_multi_generator with a table-driven float adder responder and stream monitor.
module tb_pls_multi_generator;
  localparam int DW = 32;
  localparam int NG = 4;
  localparam int CW = 16;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic            aresetn, start, stop, busy;
  logic [1:0]      group_select;
  logic [NG*DW-1:0] cfg_base, cfg_step;
  logic [NG*CW-1:0] cfg_width, cfg_period, cfg_count;
  logic [DW-1:0]   add_a_tdata, add_b_tdata, add_result_tdata, m_axis_signal_tdata;
  logic            add_a_tvalid, add_b_tvalid, add_a_tready, add_b_tready;
  logic            add_result_tvalid, add_result_tready;
  logic            m_axis_signal_tvalid, m_axis_signal_tlast;
  logic            m_axis_signal_tready = 1'b1;

  logic [DW-1:0] g_base [NG];
  logic [DW-1:0] g_step [NG];
  logic [CW-1:0] g_width [NG];
  logic [CW-1:0] g_period [NG];
  logic [CW-1:0] g_count [NG];

  for (genvar g = 0; g < NG; g++) begin : g_pack
    assign cfg_base[g*DW +: DW]   = g_base[g];
    assign cfg_step[g*DW +: DW]   = g_step[g];
    assign cfg_width[g*CW +: CW]  = g_width[g];
    assign cfg_period[g*CW +: CW] = g_period[g];
    assign cfg_count[g*CW +: CW]  = g_count[g];
  end

  pls_multi_generator #(.DATA_SIZE(DW), .NUM_GROUPS(NG), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .group_select(group_select), .busy(busy),
    .cfg_base(cfg_base), .cfg_step(cfg_step), .cfg_width(cfg_width),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .add_a_tdata(add_a_tdata), .add_b_tdata(add_b_tdata),
    .add_a_tvalid(add_a_tvalid), .add_b_tvalid(add_b_tvalid),
    .add_a_tready(add_a_tready), .add_b_tready(add_b_tready),
    .add_result_tdata(add_result_tdata), .add_result_tvalid(add_result_tvalid),
    .add_result_tready(add_result_tready),
    .m_axis_signal_tdata(m_axis_signal_tdata), .m_axis_signal_tvalid(m_axis_signal_tvalid),
    .m_axis_signal_tready(m_axis_signal_tready), .m_axis_signal_tlast(m_axis_signal_tlast)
  );

  int n_vec = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int add_txn = 0;
  int stab_err = 0;
  int b_delay = 0;
  bit tog_mode = 1'b0;
  bit res_hold = 1'b0;
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  logic [DW-1:0] pat5 [5] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h0, 32'h0};

  // Only the additions the directed vectors need: 1.0+0.5 and 1.5+0.5.
  function automatic logic [DW-1:0] fadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == 32'h3F800000 && b == 32'h3F000000) return 32'h3FC00000;
    if (a == 32'h3FC00000 && b == 32'h3F000000) return 32'h40000000;
    return 32'hDEAD0001;
  endfunction

  // Stream sink and monitor; values seen here are what the next rising edge samples.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge aclk) begin
    m_axis_signal_tready = tog_mode ? ~m_axis_signal_tready : 1'b1;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_axis_signal_tvalid && m_axis_signal_tdata === prev_data)) stab_err++;
      if (m_axis_signal_tvalid && m_axis_signal_tready) begin
        beat_data.push_back(m_axis_signal_tdata);
        beat_last.push_back(m_axis_signal_tlast);
        beat_cnt++;
      end
      prev_stall = m_axis_signal_tvalid && !m_axis_signal_tready;
      prev_data  = m_axis_signal_tdata;
    end
  end

  // Adder responder sharing the generator reset.
  logic [DW-1:0] op_a, op_b;
  bit got_a, got_b, res_hs_pend;
  int b_cnt;
  initial begin
    add_a_tready = 1'b0; add_b_tready = 1'b0;
    add_result_tvalid = 1'b0; add_result_tdata = '0;
    got_a = 0; got_b = 0; res_hs_pend = 0; b_cnt = 0;
  end
  always @(negedge aclk) begin
    if (!aresetn) begin
      add_a_tready = 1'b0; add_b_tready = 1'b0; add_result_tvalid = 1'b0;
      got_a = 0; got_b = 0; res_hs_pend = 0; b_cnt = 0;
    end else begin
      if (res_hs_pend) begin add_result_tvalid = 1'b0; res_hs_pend = 0; end
      if (got_a && got_b && !add_result_tvalid && !res_hold) begin
        add_result_tdata  = fadd(op_a, op_b);
        add_result_tvalid = 1'b1;
        got_a = 0; got_b = 0;
        add_txn++;
      end
      if (add_result_tvalid && add_result_tready) res_hs_pend = 1;
      if (add_a_tvalid && !got_a) begin
        add_a_tready = 1'b1; op_a = add_a_tdata; got_a = 1;
      end else add_a_tready = 1'b0;
      add_b_tready = 1'b0;
      if (add_b_tvalid && !got_b) begin
        b_cnt++;
        if (b_cnt > b_delay) begin add_b_tready = 1'b1; op_b = add_b_tdata; got_b = 1; b_cnt = 0; end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beat_data.delete(); beat_last.delete();
    beat_cnt = 0; add_txn = 0; stab_err = 0;
  endtask

  task automatic pulse_start(input logic [1:0] gs);
    @(posedge aclk); #1 group_select = gs; start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (busy && n < limit);
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_beats(input string tag, input int cnt, input int limit);
    int n;
    n = 0;
    while (beat_cnt < cnt && n < limit) begin @(posedge aclk); n++; end
    check(tag, {31'b0, beat_cnt >= cnt}, 32'd1);
  endtask

  task automatic expect_pat(input string tag, input int nper);
    check({tag, "_cnt"}, beat_cnt, 5 * nper);
    for (int i = 0; i < 5 * nper; i++)
      check($sformatf("%s_b%0d", tag, i), beat_data[i], pat5[i % 5]);
  endtask

  task automatic set_g0();
    g_base[0] = 32'h3F800000; g_step[0] = 32'h3F000000;
    g_width[0] = 16'd3; g_period[0] = 16'd5; g_count[0] = 16'd2;
  endtask

  initial begin
    logic any;
    int n;
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; group_select = 2'd0;
    for (int g = 0; g < NG; g++) begin
      g_base[g] = '0; g_step[g] = '0; g_width[g] = '0; g_period[g] = '0; g_count[g] = '0;
    end
    set_g0();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mvalid", {31'b0, m_axis_signal_tvalid}, 32'd0);
    check("rst_addvalid", {30'b0, add_a_tvalid, add_b_tvalid}, 32'd0);
    check("rst_resready", {31'b0, add_result_tready}, 32'd0);
    check("rst_tlast", {31'b0, m_axis_signal_tlast}, 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // Basic two-period run
    clear_mon();
    pulse_start(2'd0);
    wait_idle("a_idle", 300);
    expect_pat("a", 2);
    check("a_addtxn", add_txn, 32'd4);
`ifdef PLS_TLAST_EN
    for (int i = 0; i < 10; i++)
      check($sformatf("a_tlast%0d", i), {31'b0, beat_last[i]}, {31'b0, (i == 4 || i == 9)});
`else
    any = 1'b0;
    foreach (beat_last[i]) any |= beat_last[i];
    check("a_tlast_zero", {31'b0, any}, 32'd0);
`endif

    // Backpressure on the stream and a slow adder B channel
    clear_mon();
    tog_mode = 1'b1; b_delay = 3;
    pulse_start(2'd0);
    wait_idle("b_idle", 600);
    expect_pat("b", 2);
    check("b_addtxn", add_txn, 32'd4);
    check("b_stable", stab_err, 32'd0);
    tog_mode = 1'b0; b_delay = 0;

    // Width clamped to period, and a start while busy is ignored
    @(posedge aclk); #1;
    g_base[3] = 32'h3F800000; g_step[3] = 32'h3F000000;
    g_width[3] = 16'd7; g_period[3] = 16'd3; g_count[3] = 16'd1;
    clear_mon();
    pulse_start(2'd3);
    wait_beats("c_beat1", 1, 50);
    #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
    wait_idle("c_idle", 200);
    check("c_cnt", beat_cnt, 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("c_b%0d", i), beat_data[i], pat5[i]);
    check("c_addtxn", add_txn, 32'd2);

    // Zero period and start-with-stop do not launch
    @(posedge aclk); #1 g_period[3] = 16'd0;
    pulse_start(2'd3);
    repeat (3) @(negedge aclk);
    check("d_period0_busy", {31'b0, busy}, 32'd0);
    @(posedge aclk); #1 group_select = 2'd0; start = 1'b1; stop = 1'b1;
    @(posedge aclk); #1 start = 1'b0; stop = 1'b0;
    @(negedge aclk);
    check("d_startstop_busy", {31'b0, busy}, 32'd0);

    // Continuous run stopped after beat 5
    @(posedge aclk); #1;
    g_base[2] = 32'h3F800000; g_step[2] = 32'h3F000000;
    g_width[2] = 16'd2; g_period[2] = 16'd2; g_count[2] = 16'd0;
    clear_mon();
    pulse_start(2'd2);
    wait_beats("e_beat5", 5, 100);
    #1 stop = 1'b1;
    @(posedge aclk); #1 stop = 1'b0;
    wait_idle("e_idle", 50);
    n = add_txn;
    any = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      any |= add_a_tvalid | add_b_tvalid | m_axis_signal_tvalid;
    end
    check("e_cnt_range", {31'b0, beat_cnt >= 5 && beat_cnt <= 6}, 32'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("e_b%0d", i), beat_data[i], (i % 2 == 0) ? 32'h3F800000 : 32'h3FC00000);
    check("e_quiet", {31'b0, any}, 32'd0);
    check("e_addtxn_frozen", add_txn, n);

    // Group switch mid-period takes effect at the period boundary
    @(posedge aclk); #1;
    g_base[1] = 32'h12345678; g_step[1] = 32'h3F000000;
    g_width[1] = 16'd0; g_period[1] = 16'd4; g_count[1] = 16'd2;
    clear_mon();
    pulse_start(2'd0);
    wait_beats("f_beat2", 2, 50);
    #1 group_select = 2'd1;
    wait_idle("f_idle", 300);
    check("f_cnt", beat_cnt, 32'd9);
    for (int i = 0; i < 5; i++) check($sformatf("f_b%0d", i), beat_data[i], pat5[i]);
    for (int i = 5; i < 9; i++) check($sformatf("f_b%0d", i), beat_data[i], 32'h0);
    check("f_addtxn", add_txn, 32'd2);

    // Reset while waiting on the adder result
    res_hold = 1'b1;
    clear_mon();
    pulse_start(2'd0);
    n = 0;
    while (!add_result_tready && n < 50) begin @(negedge aclk); n++; end
    check("g_in_wait", {31'b0, add_result_tready}, 32'd1);
    @(posedge aclk); #1 aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("g_rst_busy", {31'b0, busy}, 32'd0);
    check("g_rst_mvalid", {31'b0, m_axis_signal_tvalid}, 32'd0);
    check("g_rst_addvalid", {30'b0, add_a_tvalid, add_b_tvalid}, 32'd0);
    check("g_rst_resready", {31'b0, add_result_tready}, 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1; res_hold = 1'b0;
    clear_mon();
    pulse_start(2'd0);
    wait_idle("g_idle", 300);
    expect_pat("g", 2);
    check("g_addtxn", add_txn, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed busy=%0b required completion", busy);
    $fatal(1, "watchdog");
  end

endmodule
